pattern_ram_arbiter: RTL and testbench
======================================

// Module: pattern_ram_arbiter
// PURPOSE
// - Owns the single-port pattern block RAM. Shares it between the UART host (read/write) and pattern_gen (read-only).
// - pattern_gen has absolute priority while pattern_active is high. Host accesses are stalled, or aborted and re-issued later.
// - Sits between uart register decode, pattern_gen and the BRAM instance. Drives the only RAM address, write-enable and data lines.
// PARAMETERS
// - RAM_ADDR_BITS   8    RAM address width; depth = 2**RAM_ADDR_BITS bytes
// - RAM_RD_LATENCY  1    BRAM read latency in clk cycles (1 or 2 supported)
// - STALL_CNT_BITS  16   width of the saturating host-stall counter
// PORTS
// - clk               in   1    system clock
// - rst               in   1    asynchronous, active-high reset
// - host_req          in   1    level; held high by host until host_ack
// - host_we           in   1    1 = write, 0 = read; stable while host_req is high
// - host_addr         in   RAM_ADDR_BITS  host address; stable while host_req is high
// - host_wdata        in   8    host write data
// - host_ack          out  1    1-cycle pulse; access complete
// - host_rdata        out  8    read data; valid in the host_ack cycle, held until the next read ack
// - pat_active        in   1    pattern_gen pattern_active
// - pat_addr          in   RAM_ADDR_BITS  pattern_gen RAM address
// - pat_rdata         out  8    RAM data to pattern_gen (direct pass of ram_rdata)
// - ram_addr          out  RAM_ADDR_BITS  BRAM address
// - ram_we            out  1    BRAM write enable
// - ram_wdata         out  8    BRAM write data
// - ram_rdata         in   8    BRAM read data
// - pat_owner         out  1    1 while FSM is in PAT
// - host_stall_cnt    out  STALL_CNT_BITS  cycles with host_req high and no ack; saturates; cleared by host_stall_clr
// - host_stall_clr    in   1    synchronous clear of host_stall_cnt
// BEHAVIOUR
// - Reset values:
//   - all outputs 0
//   - FSM = IDLE
//   - host_rdata = 8'h00
// - FSM states: IDLE, HWR, HRD, PAT.
//   - IDLE:
//     - pat_active -> PAT. Has priority over host_req in the same cycle.
//     - else host_req & host_we -> HWR.
//     - else host_req & !host_we -> HRD; the read is issued and the latency counter is loaded with RAM_RD_LATENCY.
//   - HWR:
//     - ram_we=1, ram_addr=host_addr, ram_wdata=host_wdata for exactly 1 cycle; host_ack=1 in that cycle -> IDLE.
//     - If pat_active rises during HWR, the write still completes and PAT is entered next cycle.
//   - HRD:
//     - ram_addr=host_addr; counter decrements each cycle.
//     - At 0: host_rdata<=ram_rdata and host_ack pulses -> IDLE.
//     - If pat_active goes high before ack: abort, no ack, -> PAT. The read is re-issued from IDLE after PAT.
//   - PAT:
//     - ram_addr=pat_addr combinationally; ram_we forced 0.
//     - Stays while pat_active. On pat_active low -> IDLE; a pending host_req is served next cycle.
// - ram_addr mux is combinational from state. ram_we is combinational, high only in HWR.
// - Back-to-back host accesses: host must drop host_req for at least 1 cycle after host_ack. IDLE ignores host_req in the cycle after an ack.
// - host_stall_cnt:
//   - +1 each cycle host_req=1 and host_ack=0, saturating at all-ones.
//   - host_stall_clr has priority over increment.
// - Reset mid-operation: FSM returns to IDLE immediately, ram_we drops asynchronously, and no ack is issued.
// - host_addr beyond depth is not possible (width-matched); no wrap logic needed.
// STRUCTURE
// - Package pattern_pkg:
//   - typedef enum logic [1:0] {IDLE,HWR,HRD,PAT} ram_arb_state_t
//   - localparam RAM_ADDR_BITS_DEF = 8
// - Single module; no sub-module. The latency counter and stall counter are inline.
// TESTING
// - Host write: addr 8'h10, data 8'hA5 -> ram_we high 1 cycle, host_ack 1 cycle later than req.
//   Then a read of 8'h10 -> host_rdata=8'hA5 with ack RAM_RD_LATENCY+1 cycles after req.
// - pat_active=1 with pat_addr sweeping 0..7 -> ram_addr tracks pat_addr each cycle and ram_we=0 throughout.
//   host_req asserted mid-pattern -> no ack until 1-2 cycles after pat_active falls.
// - host_req read and pat_active rise in the same cycle -> PAT entered; read served after PAT with correct data.
// - Host read in HRD, pat_active rises before ack -> no ack during PAT; after PAT, ack with data re-read.
// - Host write in HWR coinciding with a pat_active rise -> write lands (verify by readback), PAT follows next cycle.
// - Hold host_req for 70000 cycles during PAT with STALL_CNT_BITS=16 -> host_stall_cnt=16'hFFFF.
//   Pulse host_stall_clr -> 0. Assert rst mid-HRD -> all outputs 0, no ack.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared types for the pattern RAM arbiter: FSM state encoding and default RAM geometry.
package pattern_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HWR  = 2'd1,
        HRD  = 2'd2,
        PAT  = 2'd3
    } ram_arb_state_t;

    localparam int RAM_ADDR_BITS_DEF = 8;

endpackage

// File: rtl/pattern_ram_arbiter.sv
// Single-port pattern RAM arbiter: pattern_gen owns the RAM while active, the host gets it otherwise.
// Latency: write ack 1 cycle after req, read ack RAM_RD_LATENCY+1 cycles after req.
// Backpressure: host_req is stalled during PAT; an in-flight read is aborted and re-issued afterwards.
module pattern_ram_arbiter
    import pattern_pkg::*;
#(
    parameter int RAM_ADDR_BITS  = RAM_ADDR_BITS_DEF,
    parameter int RAM_RD_LATENCY = 1,
    parameter int STALL_CNT_BITS = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      host_req,
    input  logic                      host_we,
    input  logic [RAM_ADDR_BITS-1:0]  host_addr,
    input  logic [7:0]                host_wdata,
    output logic                      host_ack,
    output logic [7:0]                host_rdata,
    input  logic                      pat_active,
    input  logic [RAM_ADDR_BITS-1:0]  pat_addr,
    output logic [7:0]                pat_rdata,
    output logic [RAM_ADDR_BITS-1:0]  ram_addr,
    output logic                      ram_we,
    output logic [7:0]                ram_wdata,
    input  logic [7:0]                ram_rdata,
    output logic                      pat_owner,
    output logic [STALL_CNT_BITS-1:0] host_stall_cnt,
    input  logic                      host_stall_clr
);

    ram_arb_state_t state, state_nxt;
    logic [1:0]     lat_cnt;
    logic           rd_done;
    logic           rd_ack_q;
    logic           ack_q;
    logic           host_go;

    // A request is only taken when no ack is showing now or was shown last cycle,
    // so a host still holding req while it observes its ack is not served twice.
    assign host_go   = host_req & ~host_ack & ~ack_q;
    assign host_ack  = (state == HWR) | rd_ack_q;
    assign pat_owner = (state == PAT);
    assign pat_rdata = ram_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lat_cnt    <= 2'd0;
            rd_ack_q   <= 1'b0;
            ack_q      <= 1'b0;
            host_rdata <= 8'h00;
        end else begin
            state    <= state_nxt;
            ack_q    <= host_ack;
            rd_ack_q <= rd_done;
            if (rd_done)
                host_rdata <= ram_rdata;
            // The IDLE cycle already presents the read address, so one cycle of latency is spent there.
            if (state == IDLE && state_nxt == HRD)
                lat_cnt <= 2'(RAM_RD_LATENCY - 1);
            else if (state == HRD && lat_cnt != 2'd0)
                lat_cnt <= lat_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            host_stall_cnt <= '0;
        else if (host_stall_clr)
            host_stall_cnt <= '0;
        else if (host_req && !host_ack && host_stall_cnt != '1)
            host_stall_cnt <= host_stall_cnt + 1'b1;
    end

    always_comb begin
        state_nxt = state;
        rd_done   = 1'b0;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = 8'h00;
        case (state)
            IDLE: begin
                if (pat_active) begin
                    state_nxt = PAT;
                end else if (host_go) begin
                    state_nxt = host_we ? HWR : HRD;
                    ram_addr  = host_addr;
                end
            end
            HWR: begin
                ram_addr  = host_addr;
                ram_we    = 1'b1;
                ram_wdata = host_wdata;
                state_nxt = pat_active ? PAT : IDLE;
            end
            HRD: begin
                ram_addr = host_addr;
                if (pat_active) begin
                    state_nxt = PAT;
                end else if (lat_cnt == 2'd0) begin
                    rd_done   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            PAT: begin
                ram_addr = pat_addr;
                if (!pat_active)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pattern_ram_arbiter.sv
// Self-checking bench for pattern_ram_arbiter with a behavioural 1-cycle BRAM and an ack scoreboard.
module tb_pattern_ram_arbiter;

    localparam int AW  = 8;
    localparam int LAT = 1;
    localparam int SW  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          host_req, host_we, host_ack, pat_active, pat_owner, ram_we, host_stall_clr;
    logic [AW-1:0] host_addr, pat_addr, ram_addr;
    logic [7:0]    host_wdata, host_rdata, pat_rdata, ram_wdata, ram_rdata;
    logic [SW-1:0] host_stall_cnt;

    typedef struct packed {
        logic       is_rd;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] mem [256];

    always #5 clk = ~clk;

    pattern_ram_arbiter #(
        .RAM_ADDR_BITS (AW),
        .RAM_RD_LATENCY(LAT),
        .STALL_CNT_BITS(SW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .host_req      (host_req),
        .host_we       (host_we),
        .host_addr     (host_addr),
        .host_wdata    (host_wdata),
        .host_ack      (host_ack),
        .host_rdata    (host_rdata),
        .pat_active    (pat_active),
        .pat_addr      (pat_addr),
        .pat_rdata     (pat_rdata),
        .ram_addr      (ram_addr),
        .ram_we        (ram_we),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata),
        .pat_owner     (pat_owner),
        .host_stall_cnt(host_stall_cnt),
        .host_stall_clr(host_stall_clr)
    );

    // Behavioural single-port BRAM with one cycle read latency.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        ram_rdata = 8'h00;
    end
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && host_ack) begin
            if (sb.size() == 0) begin
                check("ack_pending", 32'(sb.size()), 1);
            end else begin
                e = sb.pop_front();
                if (e.is_rd) begin
                    check("rd_data", 32'(host_rdata), 32'(e.data));
                end else begin
                    check("wr_we", 32'(ram_we), 1);
                    check("wr_data", 32'(ram_wdata), 32'(e.data));
                end
            end
        end
    end

    task automatic host_set(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                            input bit push, input logic [7:0] expd);
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = addr;
        host_wdata = wd;
        if (push) sb.push_back({~we, (we ? wd : expd)});
    endtask

    task automatic host_wait(input int max, output int lat);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < max) begin
            @(negedge clk);
            n++;
            if (host_ack) seen = 1'b1;
        end
        if (!seen) check("ack_timeout", 32'(seen), 1);
        lat = n - 1;
        @(posedge clk); #1;
        host_req = 1'b0;
        host_we  = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst = 1'b1; host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        pat_active = 1'b0; pat_addr = '0; host_stall_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_ram_wdata", 32'(ram_wdata), 0);
        check("rst_ack", 32'(host_ack), 0);
        check("rst_rdata", 32'(host_rdata), 0);
        check("rst_owner", 32'(pat_owner), 0);
        check("rst_stall", 32'(host_stall_cnt), 0);
        @(posedge clk); #1 rst = 1'b0;

        // Basic write then read-back
        @(posedge clk); #1 host_set(1'b1, 8'h10, 8'hA5, 1'b1, 8'h00);
        host_wait(8, lat);
        check("wr_lat", 32'(lat), 1);
        @(posedge clk); #1 host_set(1'b0, 8'h10, 8'h00, 1'b1, 8'hA5);
        host_wait(8, lat);
        check("rd_lat", 32'(lat), LAT + 1);

        // Preload pattern bytes 0..7 with 8'h30+i
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1 host_set(1'b1, 8'(i), 8'(8'h30 + i), 1'b1, 8'h00);
            host_wait(8, lat);
        end

        // Pattern sweep with a host write arriving mid-pattern
        @(posedge clk); #1 pat_active = 1'b1; pat_addr = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1 pat_addr = 8'(i);
            if (i == 3) host_set(1'b1, 8'h20, 8'h5A, 1'b1, 8'h00);
            @(negedge clk);
            check("pat_owner", 32'(pat_owner), 1);
            check("pat_addr", 32'(ram_addr), 32'(i));
            check("pat_we", 32'(ram_we), 0);
            check("pat_no_ack", 32'(host_ack), 0);
            if (i > 0) check("pat_rdata", 32'(pat_rdata), 32'(8'h30 + i - 1));
        end
        @(posedge clk); #1 pat_active = 1'b0;
        host_wait(8, lat);
        check("post_pat_lat", 32'(lat), 2);

        // Read request and pattern start in the same cycle
        @(posedge clk); #1 host_set(1'b0, 8'h20, 8'h00, 1'b1, 8'h5A);
        pat_active = 1'b1;
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            check("same_cyc_owner", 32'(pat_owner), 1);
            check("same_cyc_no_ack", 32'(host_ack), 0);
        end
        @(posedge clk); #1 pat_active = 1'b0;
        host_wait(8, lat);
        check("same_cyc_lat", 32'(lat), LAT + 2);

        // Read aborted in HRD by a pattern start, then re-issued
        @(posedge clk); #1 host_set(1'b0, 8'h10, 8'h00, 1'b1, 8'hA5);
        @(posedge clk); #1 pat_active = 1'b1;
        @(negedge clk);
        check("abort_no_ack_hrd", 32'(host_ack), 0);
        repeat (3) begin
            @(negedge clk);
            check("abort_owner", 32'(pat_owner), 1);
            check("abort_no_ack", 32'(host_ack), 0);
        end
        @(posedge clk); #1 pat_active = 1'b0;
        host_wait(8, lat);
        check("abort_lat", 32'(lat), LAT + 2);

        // Write completing while the pattern starts
        @(posedge clk); #1 host_set(1'b1, 8'h30, 8'hC3, 1'b1, 8'h00);
        @(posedge clk); #1 pat_active = 1'b1;
        host_wait(4, lat);
        check("wr_pat_lat", 32'(lat), 0);
        @(negedge clk);
        check("wr_pat_owner", 32'(pat_owner), 1);
        @(posedge clk); #1 pat_active = 1'b0;
        @(posedge clk); #1 host_set(1'b0, 8'h30, 8'h00, 1'b1, 8'hC3);
        host_wait(8, lat);

        // Stall counter saturation and clear
        @(posedge clk); #1 pat_active = 1'b1;
        host_set(1'b0, 8'h30, 8'h00, 1'b1, 8'hC3);
        repeat (70000) @(posedge clk);
        @(negedge clk);
        check("stall_sat", 32'(host_stall_cnt), 32'hFFFF);
        @(posedge clk); #1 host_stall_clr = 1'b1;
        @(posedge clk); #1 host_stall_clr = 1'b0;
        @(negedge clk);
        check("stall_clr", 32'(host_stall_cnt), 0);
        @(negedge clk);
        check("stall_restart", 32'(host_stall_cnt), 1);
        @(posedge clk); #1 pat_active = 1'b0;
        host_wait(8, lat);

        // Reset during HWR drops ram_we asynchronously
        @(posedge clk); #1 host_set(1'b1, 8'h40, 8'h77, 1'b0, 8'h00);
        @(posedge clk); #1;
        check("hwr_we_before_rst", 32'(ram_we), 1);
        rst = 1'b1; host_req = 1'b0;
        #1;
        check("hwr_rst_we", 32'(ram_we), 0);
        check("hwr_rst_ack", 32'(host_ack), 0);
        @(posedge clk); #1 rst = 1'b0;

        // Reset during HRD: everything clears, no ack
        @(posedge clk); #1 host_set(1'b0, 8'h10, 8'h00, 1'b0, 8'h00);
        @(posedge clk); #1;
        rst = 1'b1; host_req = 1'b0; host_addr = '0;
        #1;
        check("hrd_rst_ack", 32'(host_ack), 0);
        check("hrd_rst_rdata", 32'(host_rdata), 0);
        check("hrd_rst_addr", 32'(ram_addr), 0);
        check("hrd_rst_we", 32'(ram_we), 0);
        check("hrd_rst_owner", 32'(pat_owner), 0);
        check("hrd_rst_stall", 32'(host_stall_cnt), 0);
        repeat (3) begin
            @(negedge clk);
            check("hrd_rst_no_ack", 32'(host_ack), 0);
        end
        @(posedge clk); #1 rst = 1'b0;

        // RAM contents survive the arbiter reset
        @(posedge clk); #1 host_set(1'b0, 8'h10, 8'h00, 1'b1, 8'hA5);
        host_wait(8, lat);
        check("post_rst_rd_lat", 32'(lat), LAT + 1);

        repeat (4) @(posedge clk);
        check("sb_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
